bcd_scan_driver: RTL and testbench

//   Upstream feeder for the 7-segment decoder. It converts a binary value to packed BCD

---
 rtl/bcd_scan_driver.sv | 136 +++++++++++++
 tb/tb_bcd_scan_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a time-multiplexed
// digit bus with one-hot digit enables for a common-cathode display.
module bcd_scan_driver #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_LZ  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 overflow,
  output logic [3:0]           digit_out,
  output logic [DIGITS-1:0]    digit_sel
);

  localparam int unsigned AW   = 4*DIGITS + 4;
  localparam int unsigned DW   = 4*DIGITS;
  localparam int unsigned CW   = $clog2(BIN_WIDTH + 1);
  localparam int unsigned PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW   = $clog2(DIGITS);
  localparam logic [63:0] MAXV = 64'(10**DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                     state, state_n;
  logic [BIN_WIDTH-1:0]       bin_sr;
  logic [AW-1:0]              bcd, bcd_adj;
  logic [AW+BIN_WIDTH-1:0]    shifted;
  logic [CW-1:0]              cnt;
  logic                       ovf_cap;
  logic [DW-1:0]              disp, disp_d, blanked;
  logic                       seen;
  logic [PW-1:0]              presc, presc_n;
  logic [IW-1:0]              idx, idx_n;
  logic                       tc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (load) state_n = CONV;
      CONV:    if (cnt == CW'(BIN_WIDTH - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_sr} << 1;
  end

  // Scan from the top digit down; zeros stay blanked until the first nonzero digit.
  always_comb begin
    blanked = bcd[DW-1:0];
    seen    = 1'b0;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      if (!seen && bcd[4*(DIGITS-1-k) +: 4] == 4'd0) begin
        if (BLANK_LZ != 0) blanked[4*(DIGITS-1-k) +: 4] = 4'hF;
      end else begin
        seen = 1'b1;
      end
    end
  end

  always_comb begin
    disp_d = disp;
    if (state == DONE) disp_d = ovf_cap ? '1 : blanked;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr   <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_cap  <= 1'b0;
      overflow <= 1'b0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin_sr  <= bin_in;
          bcd     <= '0;
          cnt     <= '0;
          ovf_cap <= (64'(bin_in) > MAXV);
        end
        CONV: begin
          bcd    <= shifted[AW+BIN_WIDTH-1:BIN_WIDTH];
          bin_sr <= shifted[BIN_WIDTH-1:0];
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          disp     <= disp_d;
          overflow <= ovf_cap;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tc      = (presc == PW'(SCAN_DIV - 1));
    presc_n = tc ? '0 : presc + PW'(1);
    idx_n   = idx;
    if (tc) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  // Select and digit come from the same next index and the same-cycle display
  // value, so a fresh conversion shows up right after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      idx       <= '0;
      digit_sel <= DIGITS'(1);
      digit_out <= '0;
    end else begin
      presc     <= presc_n;
      idx       <= idx_n;
      digit_sel <= DIGITS'(1) << idx_n;
      digit_out <= disp_d[4*idx_n +: 4];
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench for bcd_scan_driver: directed and random loads compared
// against a decimal-arithmetic model of conversion timing, display and scanning.
module tb_bcd_scan_driver;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [13:0] bin_in;
  logic        busy, overflow;
  logic [3:0]  digit_out, digit_sel;
  logic        busy1, ovf1;
  logic [3:0]  dout1, dsel1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_scan_driver #(.DIGITS(4), .BIN_WIDTH(14), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .load(load), .bin_in(bin_in),
    .busy(busy), .overflow(overflow), .digit_out(digit_out), .digit_sel(digit_sel)
  );

  bcd_scan_driver #(.DIGITS(4), .BIN_WIDTH(14), .SCAN_DIV(1), .BLANK_LZ(1)) dut1 (
    .clk(clk), .rst(rst), .load(1'b0), .bin_in(14'd0),
    .busy(busy1), .overflow(ovf1), .digit_out(dout1), .digit_sel(dsel1)
  );

  // Reference model: edge count since reset, cycles of busy remaining, decimal display.
  int          n;
  int          left;
  int unsigned mval;
  bit          movf;
  logic [3:0]  mdisp [4];

  function automatic int unsigned pow10(input int e);
    int unsigned p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [3:0] exp_digit(input int unsigned v, input int i);
    if (v > 9999) return 4'hF;
    if (i > 0 && v < pow10(i)) return 4'hF;
    return 4'((v / pow10(i)) % 10);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      n = 0; left = 0; movf = 1'b0;
      for (int i = 0; i < 4; i++) mdisp[i] = 4'h0;
    end else begin
      n++;
      if (left == 0) begin
        if (load) begin mval = bin_in; left = 15; end
      end else begin
        left--;
        if (left == 0) begin
          movf = (mval > 9999);
          for (int i = 0; i < 4; i++) mdisp[i] = exp_digit(mval, i);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy",      32'(busy),      32'(left > 0));
    chk("overflow",  32'(overflow),  32'(movf));
    chk("digit_sel", 32'(digit_sel), 32'(1 << ((n / 4) % 4)));
    chk("digit_out", 32'(digit_out), 32'(mdisp[(n / 4) % 4]));
    chk("sel_div1",  32'(dsel1),     32'(1 << (n % 4)));
    chk("out_div1",  32'(dout1),     32'd0);
    chk("busy_div1", 32'(busy1),     32'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int cycles);
    repeat (cycles) tick();
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 50) begin tick(); g++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic load_val(input logic [13:0] v);
    int c, g;
    bin_in = v;
    load   = 1'b1;
    tick();
    load = 1'b0;
    c = busy ? 1 : 0;
    g = 0;
    while (busy && g < 40) begin
      tick();
      g++;
      if (busy) c++;
    end
    chk("busy_len", 32'(c), 32'd15);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bin_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy),      32'd0);
    chk("reset_ovf",  32'(overflow),  32'd0);
    chk("reset_sel",  32'(digit_sel), 32'b0001);
    chk("reset_out",  32'(digit_out), 32'd0);
    check_all();
    rst = 1'b0;
    run(8);

    load_val(14'd1234);  run(20);
    load_val(14'd7);     run(16);
    load_val(14'd0);     run(16);
    load_val(14'd10000); run(16);
    chk("ovf_10000", 32'(overflow), 32'd1);
    load_val(14'd9999);  run(16);
    chk("ovf_9999",  32'(overflow), 32'd0);

    // Second load during busy must be dropped.
    bin_in = 14'd42; load = 1'b1; tick(); load = 1'b0;
    run(4);
    bin_in = 14'd99; load = 1'b1; tick(); load = 1'b0;
    wait_idle();
    run(16);
    chk("collision_val", mval, 32'd42);

    // Reset in the middle of a conversion.
    bin_in = 14'd5555; load = 1'b1; tick(); load = 1'b0;
    run(6);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    run(16);

    // Load held high restarts back to back.
    bin_in = 14'd321; load = 1'b1;
    run(40);
    load = 1'b0;
    wait_idle();
    run(8);

    for (int it = 0; it < 25; it++) begin
      int gap;
      bin_in = 14'($urandom_range(0, 16383));
      load   = 1'b1;
      tick();
      load = 1'b0;
      gap  = $urandom_range(0, 20);
      repeat (gap) begin
        if ($urandom_range(0, 3) == 0) begin
          bin_in = 14'($urandom);
          load   = 1'b1;
        end
        tick();
        load = 1'b0;
      end
    end
    wait_idle();
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
